// File: rtl/req_arbiter.sv
// req_arbiter: 16-way request arbiter with fixed or round-robin priority,
// a bounded grant length and a one-cycle gap between grants.
//
// state | meaning
// IDLE  | no grant; arbitrate on any non-zero req
// GRANT | grant held for the winner until done or the hold limit
// GAP   | single dead cycle after a grant, then back to IDLE
module req_arbiter #(
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_valid,
    output logic [7:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] IDX_NONE  = 8'hF0;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q;
    logic [3:0]  last_idx_q;
    logic [7:0]  hold_cnt_q;
    logic        grant_valid_q;
    logic [7:0]  grant_idx_q;
    logic [15:0] grant_onehot_q;
    logic        timeout_q;
    logic        busy_q;

    logic [3:0]  win_idx_d;
    logic        hold_end;

    // Winner select: round-robin scans downward from last_idx-1 and wraps,
    // ending on last_idx itself; fixed mode takes the highest set bit.
    always_comb begin
        logic       found;
        logic [3:0] cand;
        found     = 1'b0;
        cand      = 4'd0;
        win_idx_d = 4'd0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= 16; k++) begin
                cand = last_idx_q - 4'(k);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    win_idx_d = cand;
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (req[i]) begin
                    win_idx_d = 4'(i);
                end
            end
        end
    end

    assign hold_end = (hold_cnt_q == HOLD_LAST);

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_idx_q     <= 4'd0;
            hold_cnt_q     <= 8'd0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= IDX_NONE;
            grant_onehot_q <= 16'd0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 16'd0) begin
                        state_q        <= GRANT;
                        last_idx_q     <= win_idx_d;
                        hold_cnt_q     <= 8'd0;
                        grant_valid_q  <= 1'b1;
                        grant_idx_q    <= {4'd0, win_idx_d};
                        grant_onehot_q <= 16'd1 << win_idx_d;
                        busy_q         <= 1'b1;
                    end
                end
                GRANT: begin
                    if (done || hold_end) begin
                        // A release on the last allowed cycle is still a release.
                        state_q        <= GAP;
                        hold_cnt_q     <= 8'd0;
                        grant_valid_q  <= 1'b0;
                        grant_idx_q    <= IDX_NONE;
                        grant_onehot_q <= 16'd0;
                        timeout_q      <= ~done;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    hold_cnt_q     <= 8'd0;
                    grant_valid_q  <= 1'b0;
                    grant_idx_q    <= IDX_NONE;
                    grant_onehot_q <= 16'd0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: one round-robin instance (MAX_HOLD=4) and one
// fixed-priority instance. Expected grants are queued by the stimulus and
// checked by an independent monitor.
module tb_req_arbiter;

    typedef struct {
        logic [7:0] idx;
        int         len;
        logic       to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_a, req_b;
    logic        done_a, done_b;
    logic        gv  [2];
    logic [7:0]  gi  [2];
    logic [15:0] goh [2];
    logic        to  [2];
    logic        bz  [2];

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    req_arbiter #(.RR_EN(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .grant_valid(gv[0]), .grant_idx(gi[0]), .grant_onehot(goh[0]),
        .timeout(to[0]), .busy(bz[0])
    );

    req_arbiter #(.RR_EN(0)) u_fix (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .grant_valid(gv[1]), .grant_idx(gi[1]), .grant_onehot(goh[1]),
        .timeout(to[1]), .busy(bz[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int d, input string nm);
        int n;
        n = 0;
        while (gv[d] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({nm, " grant arrives"}, 32'(gv[d]), 32'd1);
    endtask

    // Monitor: pops an expectation at each grant start, checks it at the end.
    logic in_g  [2] = '{1'b0, 1'b0};
    int   len_c [2] = '{0, 0};
    exp_t cur   [2];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (gv[d] === 1'b1 && !in_g[d]) begin
                    exp_t e;
                    logic have;
                    have = 1'b0;
                    e    = '{8'hF0, 0, 1'b0};
                    if (d == 0 && q_a.size() > 0) begin
                        e = q_a.pop_front(); have = 1'b1;
                    end else if (d == 1 && q_b.size() > 0) begin
                        e = q_b.pop_front(); have = 1'b1;
                    end
                    chk($sformatf("dut%0d grant expected", d), 32'(have), 32'd1);
                    chk($sformatf("dut%0d grant_idx", d), 32'(gi[d]), 32'(e.idx));
                    chk($sformatf("dut%0d grant_onehot", d), 32'(goh[d]), 32'd1 << e.idx);
                    chk($sformatf("dut%0d busy in grant", d), 32'(bz[d]), 32'd1);
                    cur[d]   = e;
                    in_g[d]  = 1'b1;
                    len_c[d] = 1;
                end else if (gv[d] === 1'b1) begin
                    len_c[d]++;
                    chk($sformatf("dut%0d grant_idx stable", d), 32'(gi[d]), 32'(cur[d].idx));
                end else if (in_g[d]) begin
                    chk($sformatf("dut%0d grant length", d), 32'(len_c[d]), 32'(cur[d].len));
                    chk($sformatf("dut%0d timeout at end", d), 32'(to[d]), 32'(cur[d].to));
                    chk($sformatf("dut%0d idx after grant", d), 32'(gi[d]), 32'hF0);
                    chk($sformatf("dut%0d onehot after grant", d), 32'(goh[d]), 32'd0);
                    in_g[d] = 1'b0;
                end else begin
                    chk($sformatf("dut%0d timeout idle", d), 32'(to[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_a = '0; req_b = '0; done_a = 1'b0; done_b = 1'b0;
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            chk("reset grant_valid", 32'(gv[d]), 32'd0);
            chk("reset grant_idx", 32'(gi[d]), 32'hF0);
            chk("reset grant_onehot", 32'(goh[d]), 32'd0);
            chk("reset timeout", 32'(to[d]), 32'd0);
            chk("reset busy", 32'(bz[d]), 32'd0);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle with done toggling
        for (int i = 0; i < 20; i++) begin
            done_a = i[0];
            done_b = i[0];
            step();
            chk("idle grant_valid", 32'(gv[0]), 32'd0);
            chk("idle busy", 32'(bz[0]), 32'd0);
            chk("idle grant_idx", 32'(gi[0]), 32'hF0);
            chk("idle busy fix", 32'(bz[1]), 32'd0);
        end
        done_a = 1'b0; done_b = 1'b0;

        // Fixed priority: 8001 always grants 15
        for (int g = 0; g < 3; g++) q_b.push_back('{8'd15, 3, 1'b0});
        req_b = 16'h8001;
        for (int g = 0; g < 3; g++) begin
            wait_grant(1, "fixed");
            step(); step();
            done_b = 1'b1;
            if (g == 2) req_b = 16'h0000;
            step();
            done_b = 1'b0;
        end
        step(); step(); step(); step();

        // Round-robin: 8421 -> 15,10,5,0,15
        q_a.push_back('{8'd15, 1, 1'b0});
        q_a.push_back('{8'd10, 1, 1'b0});
        q_a.push_back('{8'd5,  1, 1'b0});
        q_a.push_back('{8'd0,  1, 1'b0});
        q_a.push_back('{8'd15, 1, 1'b0});
        req_a = 16'h8421;
        for (int g = 0; g < 5; g++) begin
            wait_grant(0, "rr");
            done_a = 1'b1;
            if (g == 4) req_a = 16'h0000;
            step();
            done_a = 1'b0;
            chk("rr gap busy", 32'(bz[0]), 32'd1);
            chk("rr gap valid", 32'(gv[0]), 32'd0);
            step();
            chk("rr idle busy", 32'(bz[0]), 32'd0);
            chk("rr idle valid", 32'(gv[0]), 32'd0);
            if (g < 4) begin
                step();
                chk("rr back-to-back grant", 32'(gv[0]), 32'd1);
            end
        end
        step(); step();

        // Timeout after 4 cycles, then re-grant
        q_a.push_back('{8'd4, 4, 1'b1});
        q_a.push_back('{8'd4, 1, 1'b0});
        req_a = 16'h0010;
        wait_grant(0, "timeout");
        step(); step(); step(); step();
        chk("timeout pulse", 32'(to[0]), 32'd1);
        chk("timeout idx", 32'(gi[0]), 32'hF0);
        step();
        chk("timeout one cycle", 32'(to[0]), 32'd0);
        wait_grant(0, "regrant");
        done_a = 1'b1;
        req_a  = 16'h0000;
        step();
        done_a = 1'b0;
        step(); step(); step();

        // done on the last allowed cycle, req dropped mid-grant
        q_a.push_back('{8'd4, 4, 1'b0});
        req_a = 16'h0010;
        wait_grant(0, "simul");
        step();
        req_a = 16'h0000;
        step(); step();
        done_a = 1'b1;
        step();
        done_a = 1'b0;
        chk("simul no timeout", 32'(to[0]), 32'd0);
        chk("simul in gap", 32'(bz[0]), 32'd1);
        step(); step(); step();

        // Reset mid-grant on index 7
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_a.push_back('{8'd7, 2, 1'b0});
        q_a.push_back('{8'd7, 1, 1'b0});
        req_a = 16'h0081;
        wait_grant(0, "pre-reset");
        step();
        rst = 1'b1;
        step();
        chk("midreset valid", 32'(gv[0]), 32'd0);
        chk("midreset idx", 32'(gi[0]), 32'hF0);
        chk("midreset busy", 32'(bz[0]), 32'd0);
        rst = 1'b0;
        step();
        chk("post-reset grant", 32'(gv[0]), 32'd1);
        chk("post-reset idx", 32'(gi[0]), 32'd7);
        done_a = 1'b1;
        req_a  = 16'h0000;
        step();
        done_a = 1'b0;
        step(); step(); step(); step();

        chk("queue a drained", 32'(q_a.size()), 32'd0);
        chk("queue b drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin priority, 0 = fixed priority (index 15 highest).
REQ-002 Parameter MAX_HOLD, default 255: maximum grant length in cycles (range 1..255).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 req  input  16  request lines, one per requester; bit i = requester i.
REQ-006 done  input  1  release strobe from the current grant holder.
REQ-007 grant_valid  output  1  a grant is active.
REQ-008 grant_idx  output  8  index of the granted requester (0..15); 8'hF0 when no grant is active.
REQ-009 grant_onehot  output  16  one-hot grant vector; all zero when no grant is active.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked because it reached MAX_HOLD.
REQ-011 busy  output  1  high in the GRANT and GAP states.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-013 IDLE: if req != 0 on a clk edge, the next state SHALL be GRANT with the winner registered, so grant_valid is high in the cycle after the edge that sampled req (1-cycle latency); otherwise the FSM SHALL stay in IDLE.
REQ-014 Fixed mode (RR_EN=0): the winner SHALL be the highest set index of req.
REQ-015 RR mode (RR_EN=1): the search SHALL start at last_idx-1 and run downward, wrapping from 0 to 15, ending at last_idx; the first set bit wins.
REQ-016 last_idx SHALL be updated to the winner on every grant, and it SHALL reset to 0, so the first search order is 15..0.
REQ-017 GRANT: grant_idx, grant_onehot and grant_valid SHALL stay constant, and no arbitration SHALL occur.
- This holds even if the holder drops its req bit.
REQ-018 GRANT SHALL exit to GAP on the first edge where done=1 or hold_cnt = MAX_HOLD-1.
REQ-019 hold_cnt SHALL be 8 bits, clear on entry to GRANT, and increment once per GRANT cycle.
REQ-020 If done=1 and hold_cnt = MAX_HOLD-1 on the same edge, the exit SHALL count as a normal release: timeout SHALL NOT pulse.
REQ-021 On a timeout exit, timeout SHALL be high for exactly the one cycle after the exit edge, which is the first GAP cycle.
REQ-022 GAP SHALL last exactly one cycle, with grant_valid=0, grant_idx=8'hF0, grant_onehot=0 and busy=1, and then go to IDLE.
- A back-to-back grant is therefore separated by at least one GAP cycle plus one IDLE cycle.
REQ-023 done SHALL be ignored in IDLE and GAP.
REQ-024 req SHALL be ignored in GRANT and GAP.
REQ-025 grant_onehot SHALL always equal 1 << grant_idx while grant_valid=1.
REQ-026 All outputs SHALL be driven directly from registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 When rst=1 on an edge, the state SHALL become IDLE, regardless of the current state, including mid-grant and in GAP.
REQ-028 When rst=1 on an edge, last_idx=0, hold_cnt=0, grant_valid=0, grant_idx=8'hF0, grant_onehot=0, timeout=0 and busy=0.
REQ-029 rst SHALL take precedence over req and done on the same edge.
REQ-030 The first arbitration SHALL be possible on the first edge where rst=0.

Verification
REQ-031 Fixed priority: RR_EN=0, req=16'h8001 held, done pulsed after 3 GRANT cycles each time -> every grant is grant_idx=15, grant_onehot=16'h8000; index 0 is never granted.
REQ-032 Round-robin: RR_EN=1, req=16'h8421 held, done after 1 GRANT cycle each time -> grant_idx sequence 15, 10, 5, 0, 15, with each grant separated by one GAP cycle and one IDLE cycle.
REQ-033 Timeout: MAX_HOLD=4, req=16'h0010, done never asserted -> grant_idx=4 for exactly 4 cycles, then a 1-cycle timeout pulse with grant_idx=8'hF0, then a re-grant to 4 after IDLE.
REQ-034 Simultaneous events: MAX_HOLD=4, done=1 in the 4th GRANT cycle -> a normal release with timeout=0.
- Also, req dropped to 0 mid-grant -> the grant holds until done.
REQ-035 Reset mid-grant: grant on index 7 active, rst=1 for 1 cycle -> the next cycle shows grant_valid=0, grant_idx=8'hF0 and busy=0.
- With req=16'h0081 still held, the next grant is index 7, because last_idx was reset to 0.
REQ-036 Idle and empty: req=0 for 20 cycles with done toggling -> grant_valid, busy and timeout stay 0, and grant_idx stays 8'hF0.
